// File: rtl/sipo_stream_rx_if.sv
// Handshake bundle for sipo_stream_rx: word stream in, parallel frame out.
// SIPO_STREAM_RX_SYNC_EN adds the i_first marker and o_sync_err pulse.
interface sipo_stream_rx_if #(
  parameter int BIT   = 8,
  parameter int NDATA = 3
);
  localparam int CW = $clog2(NDATA + 1);

  logic                       i_valid;
  logic                       o_ready;
  logic [BIT-1:0]             i_data;
  logic                       o_valid;
  logic                       i_ready;
  logic [0:NDATA-1][BIT-1:0]  o_data;
  logic [CW-1:0]              o_count;
`ifdef SIPO_STREAM_RX_SYNC_EN
  logic                       i_first;
  logic                       o_sync_err;

  modport slave (
    input  i_valid, i_data, i_ready, i_first,
    output o_ready, o_valid, o_data, o_count, o_sync_err
  );

  modport master (
    output i_valid, i_data, i_ready, i_first,
    input  o_ready, o_valid, o_data, o_count, o_sync_err
  );
`else
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );
`endif
endinterface

// File: rtl/sipo_stream_rx.sv
// Handshaked deserializer: NDATA words of BIT bits become one double-buffered frame.
// Optional frame-start resync with error pulse when SIPO_STREAM_RX_SYNC_EN is defined.
module sipo_stream_rx #(
  parameter int BIT   = 8,
  parameter int NDATA = 3
) (
  input logic             i_clk,
  input logic             i_rst,
  sipo_stream_rx_if.slave bus
);
  localparam int CW = $clog2(NDATA + 1);
  localparam int IW = $clog2(NDATA);
  localparam logic [CW-1:0] FULL = CW'(NDATA);
  localparam logic [CW-1:0] LAST = CW'(NDATA - 1);

  logic [0:NDATA-1][BIT-1:0] coll_q, coll_d;
  logic [0:NDATA-1][BIT-1:0] out_data_q, out_data_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [IW-1:0]             slot;
  logic                      accept, take, out_free, store_word;
`ifdef SIPO_STREAM_RX_SYNC_EN
  logic                      sync_err_q, sync_err_d;
`endif

  assign bus.o_ready = (cnt_q != FULL);
  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_count = cnt_q;
`ifdef SIPO_STREAM_RX_SYNC_EN
  assign bus.o_sync_err = sync_err_q;
`endif

  assign accept   = bus.i_valid && bus.o_ready;
  assign take     = out_valid_q && bus.i_ready;
  // The output register can absorb a new frame if it is empty or emptying now.
  assign out_free = !out_valid_q || bus.i_ready;
  assign slot     = cnt_q[IW-1:0];

  always_comb begin
    coll_d      = coll_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    store_word  = 1'b0;
`ifdef SIPO_STREAM_RX_SYNC_EN
    sync_err_d  = 1'b0;
`endif

    if (take) begin
      out_valid_d = 1'b0;
    end

    if (cnt_q == FULL) begin
      // Pending full collection waits for the consumer to free the output.
      if (take) begin
        out_data_d  = coll_q;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if (accept) begin
`ifdef SIPO_STREAM_RX_SYNC_EN
      if (bus.i_first) begin
        coll_d[0]  = bus.i_data;
        cnt_d      = CW'(1);
        sync_err_d = (cnt_q != '0);
      end else if (cnt_q == '0) begin
        sync_err_d = 1'b1;
      end else begin
        store_word = 1'b1;
      end
`else
      store_word = 1'b1;
`endif
    end

    if (store_word) begin
      coll_d[slot] = bus.i_data;
      if (cnt_q == LAST) begin
        if (out_free) begin
          out_data_d  = coll_d;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = FULL;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coll_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef SIPO_STREAM_RX_SYNC_EN
      sync_err_q  <= 1'b0;
`endif
    end else begin
      coll_q      <= coll_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef SIPO_STREAM_RX_SYNC_EN
      sync_err_q  <= sync_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sipo_stream_rx.sv
// Directed self-checking bench for sipo_stream_rx (BIT=8, NDATA=3).
// SIPO_STREAM_RX_SYNC_EN also enables the resync scenario.
module tb_sipo_stream_rx;
  logic i_clk = 1'b0;
  logic i_rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  sipo_stream_rx_if #(.BIT(8), .NDATA(3)) bus ();

  sipo_stream_rx #(.BIT(8), .NDATA(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

`ifdef SIPO_STREAM_RX_SYNC_EN
  logic force_en    = 1'b0;
  logic force_first = 1'b0;
  // Outside the resync test, mark the word that starts each frame.
  assign bus.i_first = force_en ? force_first : (bus.o_count == 2'd0);
`endif

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick;
    tick;
    checks++; if (bus.o_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.o_count); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.o_ready); end
    checks++; if (bus.o_data !== 24'h000000) begin failures++; $display("[TB] FAIL reset_data: got %h expected 000000", bus.o_data); end
    i_rst = 1'b0;
  endtask

  task automatic test_basic_frame;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h11; tick;
    bus.i_data  = 8'h22; tick;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", bus.o_valid); end
    bus.i_data  = 8'h33; tick;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid: got %0b expected 1", bus.o_valid); end
    checks++; if (bus.o_data !== 24'h112233) begin failures++; $display("[TB] FAIL basic_data: got %h expected 112233", bus.o_data); end
    checks++; if (bus.o_count !== 2'd0) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 0", bus.o_count); end
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drop: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_back_to_back;
    int ready_low = 0;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (bus.o_ready !== 1'b1) ready_low++;
      bus.i_data = 8'(k);
      tick;
      if (k == 3) begin
        checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h010203) begin failures++; $display("[TB] FAIL b2b_frame1: got valid=%0b data=%h expected valid=1 data=010203", bus.o_valid, bus.o_data); end
      end
      if (k == 5) begin
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap: got %0b expected 0", bus.o_valid); end
      end
      if (k == 6) begin
        checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h040506) begin failures++; $display("[TB] FAIL b2b_frame2: got valid=%0b data=%h expected valid=1 data=040506", bus.o_valid, bus.o_data); end
      end
    end
    bus.i_valid = 1'b0;
    checks++; if (ready_low != 0) begin failures++; $display("[TB] FAIL b2b_ready: got %0d low cycles expected 0", ready_low); end
    tick;
  endtask

  task automatic test_backpressure;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.i_data = 8'(k);
      tick;
    end
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h010203) begin failures++; $display("[TB] FAIL bp_held: got valid=%0b data=%h expected valid=1 data=010203", bus.o_valid, bus.o_data); end
    checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_low: got %0b expected 0", bus.o_ready); end
    checks++; if (bus.o_count !== 2'd3) begin failures++; $display("[TB] FAIL bp_count: got %0d expected 3", bus.o_count); end
    bus.i_data = 8'h77;
    tick;
    checks++; if (bus.o_data !== 24'h010203 || bus.o_count !== 2'd3) begin failures++; $display("[TB] FAIL bp_stable: got data=%h count=%0d expected data=010203 count=3", bus.o_data, bus.o_count); end
    bus.i_ready = 1'b1;
    tick;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h040506) begin failures++; $display("[TB] FAIL bp_second: got valid=%0b data=%h expected valid=1 data=040506", bus.o_valid, bus.o_data); end
    checks++; if (bus.o_ready !== 1'b1 || bus.o_count !== 2'd0) begin failures++; $display("[TB] FAIL bp_release: got ready=%0b count=%0d expected ready=1 count=0", bus.o_ready, bus.o_count); end
    bus.i_ready = 1'b1;
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid_frame;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hAA; tick;
    bus.i_data  = 8'hBB; tick;
    bus.i_data  = 8'hCC; tick;
    bus.i_data  = 8'hDD; tick;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_count !== 2'd1) begin failures++; $display("[TB] FAIL rst_pre: got valid=%0b count=%0d expected valid=1 count=1", bus.o_valid, bus.o_count); end
    i_rst       = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_data  = 8'hEE;
    tick;
    i_rst       = 1'b0;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_count !== 2'd0 || bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_clear: got count=%0d valid=%0b expected count=0 valid=0", bus.o_count, bus.o_valid); end
    checks++; if (bus.o_data !== 24'h000000 || bus.o_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_data: got data=%h ready=%0b expected data=000000 ready=1", bus.o_data, bus.o_ready); end
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h01; tick;
    bus.i_data  = 8'h02; tick;
    bus.i_data  = 8'h03; tick;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h010203) begin failures++; $display("[TB] FAIL rst_refill: got valid=%0b data=%h expected valid=1 data=010203", bus.o_valid, bus.o_data); end
    tick;
  endtask

  task automatic test_simultaneous;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h11; tick;
    bus.i_data  = 8'h22; tick;
    bus.i_data  = 8'h33; tick;
    bus.i_data  = 8'h44; tick;
    bus.i_data  = 8'h55; tick;
    checks++; if (bus.o_ready !== 1'b1 || bus.o_data !== 24'h112233) begin failures++; $display("[TB] FAIL sim_pre: got ready=%0b data=%h expected ready=1 data=112233", bus.o_ready, bus.o_data); end
    bus.i_ready = 1'b1;
    bus.i_data  = 8'h66;
    tick;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h445566) begin failures++; $display("[TB] FAIL sim_frame: got valid=%0b data=%h expected valid=1 data=445566", bus.o_valid, bus.o_data); end
    checks++; if (bus.o_ready !== 1'b1 || bus.o_count !== 2'd0) begin failures++; $display("[TB] FAIL sim_ready: got ready=%0b count=%0d expected ready=1 count=0", bus.o_ready, bus.o_count); end
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL sim_drain: got %0b expected 0", bus.o_valid); end
  endtask

`ifdef SIPO_STREAM_RX_SYNC_EN
  task automatic test_sync;
    force_en    = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    force_first = 1'b1; bus.i_data = 8'h10; tick;
    force_first = 1'b0; bus.i_data = 8'h20; tick;
    force_first = 1'b1; bus.i_data = 8'h30; tick;
    checks++; if (bus.o_sync_err !== 1'b1 || bus.o_count !== 2'd1) begin failures++; $display("[TB] FAIL sync_err: got err=%0b count=%0d expected err=1 count=1", bus.o_sync_err, bus.o_count); end
    force_first = 1'b0; bus.i_data = 8'h40; tick;
    checks++; if (bus.o_sync_err !== 1'b0) begin failures++; $display("[TB] FAIL sync_pulse: got %0b expected 0", bus.o_sync_err); end
    bus.i_data = 8'h50; tick;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 24'h304050) begin failures++; $display("[TB] FAIL sync_frame: got valid=%0b data=%h expected valid=1 data=304050", bus.o_valid, bus.o_data); end
    bus.i_data = 8'h99; tick;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_sync_err !== 1'b1 || bus.o_count !== 2'd0) begin failures++; $display("[TB] FAIL sync_orphan: got err=%0b count=%0d expected err=1 count=0", bus.o_sync_err, bus.o_count); end
    tick;
    checks++; if (bus.o_sync_err !== 1'b0) begin failures++; $display("[TB] FAIL sync_clear: got %0b expected 0", bus.o_sync_err); end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    i_rst       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = 8'h00;
    test_reset;
    test_basic_frame;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_frame;
    test_simultaneous;
`ifdef SIPO_STREAM_RX_SYNC_EN
    test_sync;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
